ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester arbiter sharing the single-port byte-addressable BRAM (1-cycle read latency, always ready, response always accepted) between the processor memory port (requester 0) and a secondary master such as a program loader or debug port (requester 1). Grants at most one request per cycle, drives the RAM request port, and steers the RAM response back to the requester that issued it. Out-of-range addresses are absorbed locally with a zero response so neither master hangs.

## Interface
- LGSZW, 13, log2 of RAM size in 32-bit words; RAM byte address width is LGSZW+2
- clk  in  1  system clock
- resetn  in  1  reset; asynchronous and active-low
- rq0_valid / rq1_valid  in  1  request present
- rq0_ready / rq1_ready  out  1  request accepted this cycle (combinational grant)
- rq0_addr / rq1_addr  in  32  byte address
- rq0_iswrite / rq1_iswrite  in  1  1 = store
- rq0_wbe / rq1_wbe  in  4  write byte enables
- rq0_data / rq1_data  in  32  store data
- rs0_en / rs1_en  out  1  response valid; requester must accept
- rs0_data / rs1_data  out  32  response data (read data; don't-care for stores)
- ram_addr  out  LGSZW+2  RAM byte address
- ram_rq_en, ram_write_enable  out  1  RAM request / store strobe
- ram_wbe  out  4; ram_write  out  32
- ram_rs_en  in  1; ram_read  in  32  RAM response
- oob_err  out  1  sticky: an out-of-range request was seen
- conflict_cnt  out  16  saturating count of cycles with both requesters valid

## Operation
- In range: addr >> (LGSZW+2) == 0. Accepted in-range request drives ram_rq_en=1 with addr[LGSZW+1:0], iswrite, wbe, data.
- Every accepted request (read or write) gets exactly one response, one cycle later, on its own rsN port.
- Arbitration: one valid -> granted. Both valid -> round robin: grant the requester not granted at the most recent conflict; last_conflict_winner resets to 1, so requester 0 wins the first conflict.
- Pending tag register {pend_valid, pend_id, pend_oob} loaded on every accept, cleared otherwise.
- In-range response: ram_rs_en routed to rs[pend_id]_en, rs_data = ram_read.
- Out-of-range accept: ram_rq_en stays 0; next cycle rs[pend_id]_en=1, rs_data=32'h0; stores dropped; oob_err set (sticky until reset).
- Non-granted rsN_data = 32'h0; rsN_en never asserted on both ports at once.
- conflict_cnt increments each cycle rq0_valid && rq1_valid; saturates at 16'hffff.
- Simulation check: ram_rs_en=1 with pend_valid=0 or pend_oob=1 is a protocol error (fail).

## Timing
- Reset values: rq*_ready=0 (combinational, but pend/arb state cleared), rs*_en=0, rs*_data=0, ram_rq_en=0, ram_write_enable=0, oob_err=0, conflict_cnt=0, pend_valid=0, last_conflict_winner=1.
- Accept at cycle N -> response at N+1; throughput 1 request/cycle, back-to-back across requesters allowed.
- ready depends only on valids and arbiter state, never on ready (no comb loop).
- Reset mid-flight: pending response discarded; no rs*_en after reset deasserts until a new accept.

## Configuration
- RAM_ARBITER_FIXED_PRIO_EN defined: requester 0 always wins conflicts; last_conflict_winner register removed; requester 1 may starve.
- Undefined: round robin as above.

## Structure
- Package ram_arbiter_pkg: mem_rq_t struct {addr[31:0], iswrite, wbe[3:0], data[31:0]}, requester id type (1 bit), RS_OOB_DATA = 32'h0.
- Sub-module rr_grant2: 2-way grant with last-winner state (fixed priority under the macro).

## Test plan
- Single read rq0 addr 0x10, RAM returns 0xdeadbeef -> rs0_en at N+1 with 0xdeadbeef, rs1_en=0.
- Both valid for 4 cycles, reads -> grants 0,1,0,1; conflict_cnt=4; responses on matching ports one cycle later each.
- Same with RAM_ARBITER_FIXED_PRIO_EN -> grants 0,0,0,0; rq1_ready stays 0.
- rq1 store addr 0x00020000 (LGSZW=13, out of range) -> ram_rq_en=0, rs1_en at N+1 with 0, oob_err=1 and stays 1.
- rq0 store wbe=4'b0011 data 0x12345678 addr 0x8, then read 0x8 -> ram sees write then read; rs0_en on both, second returns RAM data.
- Assert resetn low in the cycle after an accept -> no response emitted, all outputs at reset values, arbiter restarts with requester 0 winning first conflict.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arbiter_pkg;

  // One memory request as presented by either master.
  typedef struct packed {
    logic [31:0] addr;
    logic        iswrite;
    logic [3:0]  wbe;
    logic [31:0] data;
  } mem_rq_t;

  // Requester identifier: 0 = processor port, 1 = secondary master.
  typedef logic rq_id_t;

  localparam rq_id_t      RQ_ID_CPU   = 1'b0;
  localparam rq_id_t      RQ_ID_AUX   = 1'b1;

  // Data returned for requests that fall outside the RAM.
  localparam logic [31:0] RS_OOB_DATA = 32'h0000_0000;

endpackage

// File: rtl/ram_arbiter_rr_grant2.sv
// Two-way grant logic. By default both-valid conflicts alternate between
// requesters (last_winner_q resets to 1 so requester 0 wins first).
// With RAM_ARBITER_FIXED_PRIO_EN defined requester 0 always wins and no
// state is kept.
module rr_grant2
  import ram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

`ifdef RAM_ARBITER_FIXED_PRIO_EN

  // Clock and reset are only needed for the round-robin state.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ resetn;

  assign gnt0_o = req0_i;
  assign gnt1_o = req1_i & ~req0_i;

`else

  rq_id_t last_winner_q;
  rq_id_t last_winner_d;

  // Grant the single valid requester, or on conflict the one that lost last time.
  always_comb begin
    gnt0_o        = req0_i & ~req1_i;
    gnt1_o        = req1_i & ~req0_i;
    last_winner_d = last_winner_q;
    if (req0_i && req1_i) begin
      if (last_winner_q == RQ_ID_AUX) begin
        gnt0_o        = 1'b1;
        last_winner_d = RQ_ID_CPU;
      end else begin
        gnt1_o        = 1'b1;
        last_winner_d = RQ_ID_AUX;
      end
    end
  end

  // Remember who won the most recent conflict.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_winner_q <= RQ_ID_AUX;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end

`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port BRAM (1-cycle read latency) between the processor
// port (requester 0) and a secondary master (requester 1). Out-of-range
// requests are answered locally with zero data and flag oob_err.
// Optional build macro: RAM_ARBITER_FIXED_PRIO_EN (requester 0 always wins).
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int LGSZW = 13
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               rq0_valid,
  output logic               rq0_ready,
  input  logic [31:0]        rq0_addr,
  input  logic               rq0_iswrite,
  input  logic [3:0]         rq0_wbe,
  input  logic [31:0]        rq0_data,
  input  logic               rq1_valid,
  output logic               rq1_ready,
  input  logic [31:0]        rq1_addr,
  input  logic               rq1_iswrite,
  input  logic [3:0]         rq1_wbe,
  input  logic [31:0]        rq1_data,
  output logic               rs0_en,
  output logic [31:0]        rs0_data,
  output logic               rs1_en,
  output logic [31:0]        rs1_data,
  output logic [LGSZW+1:0]   ram_addr,
  output logic               ram_rq_en,
  output logic               ram_write_enable,
  output logic [3:0]         ram_wbe,
  output logic [31:0]        ram_write,
  input  logic               ram_rs_en,
  input  logic [31:0]        ram_read,
  output logic               oob_err,
  output logic [15:0]        conflict_cnt
);

  mem_rq_t rq0, rq1, sel_rq;
  logic    gnt0, gnt1, accept, in_range;
  logic    pend_valid_q, pend_oob_q;
  rq_id_t  pend_id_q;
  logic    oob_err_q;
  logic [15:0] conflict_cnt_q;
  logic    rs_fire;
  logic [31:0] rs_data;

  assign rq0 = '{addr: rq0_addr, iswrite: rq0_iswrite, wbe: rq0_wbe, data: rq0_data};
  assign rq1 = '{addr: rq1_addr, iswrite: rq1_iswrite, wbe: rq1_wbe, data: rq1_data};

  // Valids are masked while in reset so ready reads 0 there.
  rr_grant2 u_grant (
    .clk    (clk),
    .resetn (resetn),
    .req0_i (rq0_valid & resetn),
    .req1_i (rq1_valid & resetn),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  assign rq0_ready = gnt0;
  assign rq1_ready = gnt1;
  assign accept    = gnt0 | gnt1;
  assign sel_rq    = gnt1 ? rq1 : rq0;
  assign in_range  = (sel_rq.addr[31:LGSZW+2] == '0);

  // Only in-range accepts reach the RAM; out-of-range stores are dropped.
  always_comb begin
    ram_rq_en        = accept & in_range;
    ram_write_enable = ram_rq_en & sel_rq.iswrite;
    ram_addr         = sel_rq.addr[LGSZW+1:0];
    ram_wbe          = ram_rq_en ? sel_rq.wbe  : 4'h0;
    ram_write        = ram_rq_en ? sel_rq.data : 32'h0;
  end

  // Pending tag tracks who owns the response due next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_valid_q <= 1'b0;
      pend_id_q    <= RQ_ID_CPU;
      pend_oob_q   <= 1'b0;
    end else begin
      pend_valid_q <= accept;
      pend_id_q    <= accept ? rq_id_t'(gnt1) : RQ_ID_CPU;
      pend_oob_q   <= accept & ~in_range;
    end
  end

  // Sticky out-of-range flag and saturating conflict counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oob_err_q      <= 1'b0;
      conflict_cnt_q <= 16'h0;
    end else begin
      if (accept && !in_range) oob_err_q <= 1'b1;
      if (rq0_valid && rq1_valid && conflict_cnt_q != 16'hffff)
        conflict_cnt_q <= conflict_cnt_q + 16'h1;
    end
  end

  assign oob_err      = oob_err_q;
  assign conflict_cnt = conflict_cnt_q;

  // Steer the RAM (or local zero) response to the requester that issued it.
  always_comb begin
    rs_fire  = pend_valid_q & (pend_oob_q | ram_rs_en);
    rs_data  = pend_oob_q ? RS_OOB_DATA : ram_read;
    rs0_en   = rs_fire & (pend_id_q == RQ_ID_CPU);
    rs1_en   = rs_fire & (pend_id_q == RQ_ID_AUX);
    rs0_data = rs0_en ? rs_data : 32'h0;
    rs1_data = rs1_en ? rs_data : 32'h0;
  end

  // A RAM response with nothing in-range pending is a protocol error.
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(ram_rs_en && (!pend_valid_q || pend_oob_q)));
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small behavioural BRAM model.
// Expectations for conflicts follow RAM_ARBITER_FIXED_PRIO_EN when defined.
module tb_ram_arbiter;
  localparam int LGSZW = 13;

  logic clk, resetn;
  logic rq0_valid, rq0_ready, rq0_iswrite; logic [31:0] rq0_addr, rq0_data; logic [3:0] rq0_wbe;
  logic rq1_valid, rq1_ready, rq1_iswrite; logic [31:0] rq1_addr, rq1_data; logic [3:0] rq1_wbe;
  logic rs0_en, rs1_en; logic [31:0] rs0_data, rs1_data;
  logic [LGSZW+1:0] ram_addr;
  logic ram_rq_en, ram_write_enable, ram_rs_en;
  logic [3:0] ram_wbe; logic [31:0] ram_write, ram_read;
  logic oob_err; logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.LGSZW(LGSZW)) dut (
    .clk(clk), .resetn(resetn),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_addr(rq0_addr),
    .rq0_iswrite(rq0_iswrite), .rq0_wbe(rq0_wbe), .rq0_data(rq0_data),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_addr(rq1_addr),
    .rq1_iswrite(rq1_iswrite), .rq1_wbe(rq1_wbe), .rq1_data(rq1_data),
    .rs0_en(rs0_en), .rs0_data(rs0_data), .rs1_en(rs1_en), .rs1_data(rs1_data),
    .ram_addr(ram_addr), .ram_rq_en(ram_rq_en), .ram_write_enable(ram_write_enable),
    .ram_wbe(ram_wbe), .ram_write(ram_write), .ram_rs_en(ram_rs_en), .ram_read(ram_read),
    .oob_err(oob_err), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BRAM: 16 words, 1-cycle latency, responds to every request.
  logic [31:0] mem [16];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ram_rs_en <= 1'b0;
      ram_read  <= 32'h0;
    end else begin
      ram_rs_en <= ram_rq_en;
      if (ram_rq_en) begin
        ram_read <= mem[ram_addr[5:2]];
        if (ram_write_enable)
          for (int b = 0; b < 4; b++)
            if (ram_wbe[b]) mem[ram_addr[5:2]][8*b +: 8] <= ram_write[8*b +: 8];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rq0_valid = 0; rq1_valid = 0;
  endtask

  task automatic drive(input int id, input logic [31:0] addr, input logic wr,
                       input logic [3:0] wbe, input logic [31:0] data);
    if (id == 0) begin
      rq0_valid = 1; rq0_addr = addr; rq0_iswrite = wr; rq0_wbe = wbe; rq0_data = data;
    end else begin
      rq1_valid = 1; rq1_addr = addr; rq1_iswrite = wr; rq1_wbe = wbe; rq1_data = data;
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  int exp_g [4];
  logic [31:0] exp_d;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222;
    mem[2] = 32'hAABB_CCDD; mem[4] = 32'hDEAD_BEEF;
`ifdef RAM_ARBITER_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    idle();
    rq0_addr = 0; rq0_iswrite = 0; rq0_wbe = 0; rq0_data = 0;
    rq1_addr = 0; rq1_iswrite = 0; rq1_wbe = 0; rq1_data = 0;

    // Reset state, with a valid held to show ready is masked.
    resetn = 0;
    drive(0, 32'h10, 0, 4'h0, 32'h0);
    #12;
    $display("txn reset");
    check_eq("rst_rq0_ready", rq0_ready, 0);
    check_eq("rst_rs0_en", rs0_en, 0);
    check_eq("rst_ram_rq_en", ram_rq_en, 0);
    check_eq("rst_oob_err", oob_err, 0);
    check_eq("rst_conflict_cnt", conflict_cnt, 0);
    idle();
    tick(); resetn = 1;

    // Single read on requester 0.
    tick();
    drive(0, 32'h10, 0, 4'h0, 32'h0); #1;
    $display("txn rd0 addr=0x10");
    check_eq("rd0_ready", rq0_ready, 1);
    check_eq("rd0_ram_rq_en", ram_rq_en, 1);
    check_eq("rd0_ram_addr", 32'(ram_addr), 32'h10);
    tick(); idle(); #1;
    check_eq("rd0_rs0_en", rs0_en, 1);
    check_eq("rd0_rs0_data", rs0_data, 32'hDEAD_BEEF);
    check_eq("rd0_rs1_en", rs1_en, 0);

    // Four conflict cycles of reads: rq0 -> 0x0, rq1 -> 0x4.
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k > 0) begin
        exp_d = (exp_g[k-1] == 0) ? 32'h1111_1111 : 32'h2222_2222;
        check_eq("rr_rs0_en", rs0_en, exp_g[k-1] == 0);
        check_eq("rr_rs1_en", rs1_en, exp_g[k-1] == 1);
        check_eq("rr_rs_data", (exp_g[k-1] == 0) ? rs0_data : rs1_data, exp_d);
      end
      drive(0, 32'h0, 0, 4'h0, 32'h0);
      drive(1, 32'h4, 0, 4'h0, 32'h0); #1;
      $display("txn conflict %0d expect grant %0d", k, exp_g[k]);
      check_eq("rr_rq0_ready", rq0_ready, exp_g[k] == 0);
      check_eq("rr_rq1_ready", rq1_ready, exp_g[k] == 1);
    end
    tick(); idle(); #1;
    exp_d = (exp_g[3] == 0) ? 32'h1111_1111 : 32'h2222_2222;
    check_eq("rr_last_rs_data", (exp_g[3] == 0) ? rs0_data : rs1_data, exp_d);
    check_eq("rr_conflict_cnt", conflict_cnt, 4);

    // Out-of-range store on requester 1.
    tick();
    drive(1, 32'h0002_0000, 1, 4'hF, 32'hCAFE_F00D); #1;
    $display("txn oob st1 addr=0x00020000");
    check_eq("oob_rq1_ready", rq1_ready, 1);
    check_eq("oob_ram_rq_en", ram_rq_en, 0);
    tick(); idle(); #1;
    check_eq("oob_rs1_en", rs1_en, 1);
    check_eq("oob_rs1_data", rs1_data, 32'h0);
    check_eq("oob_rs0_en", rs0_en, 0);
    check_eq("oob_err_set", oob_err, 1);
    tick();
    check_eq("oob_err_sticky", oob_err, 1);
    check_eq("oob_rs1_quiet", rs1_en, 0);

    // Partial store then read-back on requester 0.
    drive(0, 32'h8, 1, 4'b0011, 32'h1234_5678); #1;
    $display("txn st0 addr=0x8 wbe=0011");
    check_eq("st_ram_we", ram_write_enable, 1);
    check_eq("st_ram_wbe", 32'(ram_wbe), 32'h3);
    check_eq("st_ram_write", ram_write, 32'h1234_5678);
    tick();
    check_eq("st_rs0_en", rs0_en, 1);
    drive(0, 32'h8, 0, 4'h0, 32'h0); #1;
    $display("txn rd0 addr=0x8");
    check_eq("rb_ram_rq_en", ram_rq_en, 1);
    check_eq("rb_ram_we", ram_write_enable, 0);
    tick(); idle(); #1;
    check_eq("rb_rs0_en", rs0_en, 1);
    check_eq("rb_rs0_data", rs0_data, 32'hAABB_5678);

    // Conflict accepted, then reset in the following cycle.
    tick();
    drive(0, 32'h0, 0, 4'h0, 32'h0);
    drive(1, 32'h4, 0, 4'h0, 32'h0); #1;
    $display("txn conflict before reset");
    check_eq("pre_rst_rq0_ready", rq0_ready, 1);
    tick(); idle();
    resetn = 0; #1;
    $display("txn reset mid-flight");
    check_eq("mid_rst_rs0_en", rs0_en, 0);
    check_eq("mid_rst_rs0_data", rs0_data, 0);
    check_eq("mid_rst_oob_err", oob_err, 0);
    tick(); resetn = 1;
    tick();
    check_eq("post_rst_rs0_en", rs0_en, 0);
    check_eq("post_rst_rs1_en", rs1_en, 0);
    check_eq("post_rst_conflict_cnt", conflict_cnt, 0);
    drive(0, 32'h0, 0, 4'h0, 32'h0);
    drive(1, 32'h4, 0, 4'h0, 32'h0); #1;
    $display("txn first conflict after reset");
    check_eq("post_rst_rq0_ready", rq0_ready, 1);
    check_eq("post_rst_rq1_ready", rq1_ready, 0);
    tick(); idle(); #1;
    check_eq("post_rst_rs0_data", rs0_data, 32'h1111_1111);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
